// File: rtl/apb_master_gen.sv
// APB3/APB4 single-transfer master: takes one command at a time from a valid/ready
// request port, runs SETUP/ACCESS on one of NUM_SLV slaves, and returns a one-cycle response pulse.
module apb_master_gen #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // Command handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
    // The requester holds the command stable until then; cmd_ready is high only in IDLE.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     paddr,
    output logic [NUM_SLV-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [1:0]            state_dbg
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [SEL_W-1:0]   sel_idx;
    logic [NUM_SLV-1:0] sel_onehot;
    logic               timeout_hit;

    // Slave index comes from the top address bits; a single slave is always index 0.
    generate
        if (NUM_SLV > 1) begin : g_multi
            assign sel_idx = cmd_addr[ADDR_W-1 -: SEL_W];
        end else begin : g_single
            assign sel_idx = '0;
        end
    endgenerate

    assign sel_onehot  = NUM_SLV'(1) << sel_idx;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !pready;
    assign cmd_ready   = (state == IDLE);
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            paddr     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr    <= cmd_addr;
                        pwrite   <= cmd_write;
                        pwdata   <= cmd_write ? cmd_wdata : '0;
                        pstrb    <= cmd_write ? cmd_strb : STRB_W'(0);
                        psel     <= sel_onehot;
                        penable  <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // pslverr and prdata are only trusted on the cycle pready is high.
                    if (pready) begin
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                        rsp_valid <= 1'b1;
                        psel      <= '0;
                        penable   <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        psel      <= '0;
                        penable   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
